tx_logic: RTL and testbench

- Output stage of a router node. Pops items from the node's input fifo, the same fifo the receive stage fills.
- Decodes each item's destination field and computes an XY-mesh output port.
- Delivers the item to that port's transmitter using a two-phase req/ack handshake. One item is in flight at a time.
- Complements the receive stage: that stage is the fifo writer, this block is the fifo reader.

---
 rtl/tx_logic_pkg.sv | 21 ++
 rtl/tx_logic_route_xy.sv | 35 +++
 rtl/tx_logic.sv | 131 +++++++++++++
 tb/tb_tx_logic.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tx_logic_pkg.sv
// Shared definitions for the router output stage: port indices, FSM encoding, field widths.
package tx_logic_pkg;

   localparam int unsigned DEST_BITS = 4;

   typedef logic [2:0] port_idx_t;

   localparam port_idx_t PORT_LOCAL = 3'd0;
   localparam port_idx_t PORT_NORTH = 3'd1;
   localparam port_idx_t PORT_EAST  = 3'd2;
   localparam port_idx_t PORT_SOUTH = 3'd3;
   localparam port_idx_t PORT_WEST  = 3'd4;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StRoute,
      StWaitAck
   } state_e;

endpackage

// File: rtl/tx_logic_route_xy.sv
// Combinational XY (x first) route computation for a 2-D mesh; y grows southward.
module route_xy
   import tx_logic_pkg::*;
#(
   parameter int unsigned ID               = 0,
   parameter int unsigned COLS             = 4,
   parameter int unsigned ROWS             = 4,
   parameter int unsigned DESTINATION_BITS = DEST_BITS
) (
   input  logic [DESTINATION_BITS-1:0] dest_i,
   output port_idx_t                   port_o,
   output logic                        invalid_o
);

   localparam int unsigned X = ID % COLS;
   localparam int unsigned Y = ID / COLS;

   int unsigned d;
   int unsigned dx;
   int unsigned dy;

   always_comb begin
      d         = 32'(dest_i);
      dx        = d % COLS;
      dy        = d / COLS;
      invalid_o = (d >= ROWS * COLS);
      port_o    = PORT_LOCAL;
      if (dx != X) begin
         port_o = (dx > X) ? PORT_EAST : PORT_WEST;
      end else if (dy != Y) begin
         port_o = (dy > Y) ? PORT_SOUTH : PORT_NORTH;
      end
   end

endmodule

// File: rtl/tx_logic.sv
// Router output stage: pops the node fifo, routes XY, and delivers over a two-phase req/ack.
// Optional macro TX_LOGIC_ACK_SYNC_EN adds a two-flop synchronizer on each tx_ack bit.
module tx_logic
   import tx_logic_pkg::*;
#(
   parameter int unsigned ID               = 0,
   parameter int unsigned SIZE             = 8,
   parameter int unsigned PORT_COUNT       = 5,
   parameter int unsigned DESTINATION_BITS = DEST_BITS,
   parameter int unsigned COLS             = 4,
   parameter int unsigned ROWS             = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         fifo_empty,
   output logic                         fifo_read,
   input  logic [SIZE-1:0]              fifo_item_out,
   output logic [PORT_COUNT-1:0]        tx_req,
   input  logic [PORT_COUNT-1:0]        tx_ack,
   output logic [SIZE*PORT_COUNT-1:0]   tx_data,
   output logic                         drop
);

   state_e                             state_q, state_d;
   logic [SIZE-1:0]                    item_q, item_d;
   port_idx_t                          port_q, port_d;
   logic                               invalid_q, invalid_d;
   logic [PORT_COUNT-1:0]              tx_req_q, tx_req_d;
   logic [PORT_COUNT-1:0][SIZE-1:0]    tx_data_q, tx_data_d;
   logic [PORT_COUNT-1:0]              ack_cmp;
   port_idx_t                          route_port;
   logic                               route_invalid;

   route_xy #(
      .ID               (ID),
      .COLS             (COLS),
      .ROWS             (ROWS),
      .DESTINATION_BITS (DESTINATION_BITS)
   ) u_route_xy (
      .dest_i    (fifo_item_out[DESTINATION_BITS-1:0]),
      .port_o    (route_port),
      .invalid_o (route_invalid)
   );

`ifdef TX_LOGIC_ACK_SYNC_EN
   logic [PORT_COUNT-1:0] ack_meta_q;
   logic [PORT_COUNT-1:0] ack_sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         ack_meta_q <= '0;
         ack_sync_q <= '0;
      end else begin
         ack_meta_q <= tx_ack;
         ack_sync_q <= ack_meta_q;
      end
   end

   assign ack_cmp = ack_sync_q;
`else
   assign ack_cmp = tx_ack;
`endif

   always_comb begin
      state_d   = state_q;
      item_d    = item_q;
      port_d    = port_q;
      invalid_d = invalid_q;
      tx_req_d  = tx_req_q;
      tx_data_d = tx_data_q;
      fifo_read = 1'b0;
      drop      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               fifo_read = 1'b1;
               state_d   = StFetch;
            end
         end
         StFetch: begin
            item_d    = fifo_item_out;
            port_d    = route_port;
            invalid_d = route_invalid;
            state_d   = StRoute;
         end
         StRoute: begin
            if (invalid_q) begin
               drop    = 1'b1;
               state_d = StIdle;
            end else begin
               tx_data_d[port_q] = item_q;
               tx_req_d[port_q]  = ~tx_req_q[port_q];
               state_d           = StWaitAck;
            end
         end
         StWaitAck: begin
            if (ack_cmp[port_q] == tx_req_q[port_q]) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      // Strobes are combinational, so reset must mask them directly.
      if (reset) begin
         fifo_read = 1'b0;
         drop      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         item_q    <= '0;
         port_q    <= PORT_LOCAL;
         invalid_q <= 1'b0;
         tx_req_q  <= '0;
         tx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         item_q    <= item_d;
         port_q    <= port_d;
         invalid_q <= invalid_d;
         tx_req_q  <= tx_req_d;
         tx_data_q <= tx_data_d;
      end
   end

   assign tx_req  = tx_req_q;
   assign tx_data = tx_data_q;

endmodule

// File: tb/tb_tx_logic.sv
// Directed bench for tx_logic on a 4x3 mesh at node 5 (x1,y1), with a behavioural fifo.
module tb_tx_logic;

`ifdef TX_LOGIC_ACK_SYNC_EN
   localparam int AckLat = 2;
`else
   localparam int AckLat = 0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fifo_empty;
   logic        fifo_read;
   logic [7:0]  fifo_item_out = '0;
   logic [4:0]  tx_req;
   logic [4:0]  tx_ack = '0;
   logic [39:0] tx_data;
   logic        drop;

   logic [7:0]  mem [0:31];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   int          underflow = 0;
   int          checks = 0;
   int          errors = 0;
   logic [4:0]  exp_req = '0;
   logic [39:0] exp_data = '0;
   int          n;

   always #5 clk = ~clk;

   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_read) begin
         if (fifo_empty) underflow <= underflow + 1;
         fifo_item_out <= mem[rd_ptr % 32];
         rd_ptr        <= rd_ptr + 1;
      end
   end

   tx_logic #(
      .ID               (5),
      .SIZE             (8),
      .PORT_COUNT       (5),
      .DESTINATION_BITS (4),
      .COLS             (4),
      .ROWS             (3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .fifo_empty    (fifo_empty),
      .fifo_read     (fifo_read),
      .fifo_item_out (fifo_item_out),
      .tx_req        (tx_req),
      .tx_ack        (tx_ack),
      .tx_data       (tx_data),
      .drop          (drop)
   );

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] v);
      mem[wr_ptr % 32] = v;
      wr_ptr++;
   endtask

   task automatic wait_pop(output int cyc);
      cyc = -1;
      for (int i = 1; i <= 60; i++) begin
         tick();
         if (fifo_read === 1'b1) begin
            cyc = i;
            break;
         end
      end
   endtask

   // Call on the tick where fifo_read is seen high; p < 0 means the item must be dropped.
   task automatic do_item(input logic [7:0] item, input int p, input int hold,
                          input bit give_ack, input string tag);
      tick();
      chk(fifo_read, 0, {tag, "_fetch_nopop"});
      tick();
      chk(drop, (p < 0), {tag, "_route_drop"});
      chk(tx_req, exp_req, {tag, "_route_req"});
      if (p < 0) begin
         tick();
         chk(drop, 0, {tag, "_drop_once"});
         chk(tx_req, exp_req, {tag, "_drop_req"});
         chk(tx_data, exp_data, {tag, "_drop_data"});
      end else begin
         tick();
         exp_req[p]           = ~exp_req[p];
         exp_data[p*8 +: 8]   = item;
         chk(tx_req, exp_req, {tag, "_req"});
         chk(tx_data, exp_data, {tag, "_data"});
         for (int i = 0; i < hold; i++) begin
            tick();
            chk(fifo_read, 0, {tag, "_wait_nopop"});
            chk(tx_data, exp_data, {tag, "_wait_data"});
         end
         if (give_ack) tx_ack[p] = exp_req[p];
      end
   endtask

   initial begin
      repeat (3) tick();
      chk(tx_req, 0, "rst_req");
      chk(tx_data, 0, "rst_data");
      chk(fifo_read, 0, "rst_read");
      chk(drop, 0, "rst_drop");
      reset = 1'b0;

      tick();
      push(8'hA5);
      #1;
      chk(fifo_read, 1, "local_pop");
      do_item(8'hA5, 0, 2, 1'b1, "local");

      push(8'h37);
      wait_pop(n);
      chk(n, 1 + AckLat, "east_pop_lat");
      do_item(8'h37, 2, 2, 1'b1, "east");

      push(8'h91);
      wait_pop(n);
      chk(n, 1 + AckLat, "north_pop_lat");
      do_item(8'h91, 1, 2, 1'b1, "north");

      push(8'h69);
      wait_pop(n);
      chk(n, 1 + AckLat, "south_pop_lat");
      do_item(8'h69, 3, 2, 1'b1, "south");

      push(8'hC4);
      wait_pop(n);
      chk(n, 1 + AckLat, "west_pop_lat");
      do_item(8'hC4, 4, 2, 1'b1, "west");

      // Back-pressure: fifo stays non-empty while the ack is withheld.
      push(8'h50);
      push(8'h2E);
      wait_pop(n);
      chk(n, 1 + AckLat, "bp_pop_lat");
      do_item(8'h50, 4, 20, 1'b1, "bp_west_xfirst");
      wait_pop(n);
      chk(n, 1 + AckLat, "bp_next_pop_lat");
      do_item(8'h2E, -1, 0, 1'b0, "invalid");

      push(8'h85);
      #1;
      chk(fifo_read, 1, "after_drop_pop");
      do_item(8'h85, 0, 2, 1'b1, "after_drop");

      // Reset while waiting for an ack on port 4.
      push(8'hD4);
      wait_pop(n);
      chk(n, 1 + AckLat, "prerst_pop_lat");
      do_item(8'hD4, 4, 1, 1'b0, "prerst");
      tick();
      reset  = 1'b1;
      tx_ack = '0;
      tick();
      exp_req  = '0;
      exp_data = '0;
      chk(tx_req, 0, "midrst_req");
      chk(tx_data, 0, "midrst_data");
      chk(fifo_read, 0, "midrst_read");
      chk(drop, 0, "midrst_drop");
      reset = 1'b0;
      tx_ack[4] = 1'b1;
      repeat (3) begin
         tick();
         chk(fifo_read, 0, "stray_ack_read");
         chk(tx_req, 0, "stray_ack_req");
      end
      push(8'h35);
      #1;
      chk(fifo_read, 1, "post_rst_pop");
      do_item(8'h35, 0, 2, 1'b0, "post_rst");

      // Toggle on an unrelated port must not release the wait on port 0.
      push(8'h91);
      tx_ack[3] = 1'b1;
      repeat (4) begin
         tick();
         chk(fifo_read, 0, "spurious_ack_nopop");
      end
      tx_ack[0] = 1'b1;
      wait_pop(n);
      chk(n, 1 + AckLat, "final_pop_lat");
      repeat (3) tick();
      chk(underflow, 0, "no_underflow");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
